overlay_sched: RTL

Schedules the single 1-bit font ROM between two overlay windows on the 1080p HDMI stream. Window A is a fixed status banner; window B is a glyph string whose position moves via a key-driven request/acknowledge handshake. The block tracks pixel position from DE/VS, issues ROM addresses, and emits a latency-aligned overlay_enable for the bit combiner. It replaces the ad-hoc ROM address and enable control.

---
 rtl/overlay_pkg.sv | 39 +++
 rtl/overlay_win_hit.sv | 42 ++++
 rtl/overlay_sched.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/overlay_pkg.sv
// Shared definitions for the overlay scheduler: move direction codes, move
// FSM states, font ROM geometry, window B reset position and the clamped
// position-step helper.
package overlay_pkg;

   localparam int GLYPH_BITS = 128;   // bits per glyph in the font ROM
   localparam int ROM_AW     = 13;    // font ROM address width

   localparam logic [11:0] B_X_RST = 12'd256;
   localparam logic [10:0] B_Y_RST = 11'd64;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } move_dir_t;

   typedef enum logic [1:0] {
      IDLE,
      PEND,
      APPLY,
      ACK
   } move_state_t;

   // Move a coordinate by one step, clamped to [0, max_pos]. A decrement
   // that would go below zero stops at zero instead of wrapping.
   function automatic logic [11:0] step_clamp(input logic [11:0] pos,
                                              input logic        dec,
                                              input logic [11:0] step,
                                              input logic [11:0] max_pos);
      logic [12:0] sum;
      sum = {1'b0, pos} + {1'b0, step};
      if (dec)
         return (pos < step) ? 12'd0 : pos - step;
      return (sum > {1'b0, max_pos}) ? max_pos : sum[11:0];
   endfunction

endpackage

// File: rtl/overlay_win_hit.sv
// Hit test and font ROM address for one overlay window. Purely
// combinational; the window is N_CHARS glyphs wide and one glyph tall.
module overlay_win_hit import overlay_pkg::*; #(
   parameter int GLYPH_W = 8,
   parameter int GLYPH_H = 16,
   parameter int N_CHARS = 8
) (
   input  logic              de,
   input  logic [11:0]       x,
   input  logic [10:0]       y,
   input  logic [11:0]       win_x,
   input  logic [10:0]       win_y,
   input  logic [ROM_AW-1:0] glyph0,   // glyph index of the first character
   output logic              hit,
   output logic [ROM_AW-1:0] addr
);

   localparam int WIN_W    = N_CHARS * GLYPH_W;
   localparam int COL_BITS = $clog2(GLYPH_W);

   logic [11:0]       dx;
   logic [10:0]       dy;
   logic              in_x;
   logic              in_y;
   logic [ROM_AW-1:0] char_idx;
   logic [ROM_AW-1:0] glyph;

   // Offset into the window, inside test, and glyph/row/column address.
   always_comb begin
      dx       = x - win_x;
      dy       = y - win_y;
      in_x     = (x >= win_x) && (dx < 12'(WIN_W));
      in_y     = (y >= win_y) && (dy < 11'(GLYPH_H));
      hit      = de && in_x && in_y;
      char_idx = ROM_AW'(dx >> COL_BITS);
      glyph    = glyph0 + char_idx;
      // Address arithmetic wraps modulo the ROM size by truncation.
      addr     = ROM_AW'(glyph * GLYPH_BITS) + ROM_AW'(dy * GLYPH_W)
               + ROM_AW'(dx % GLYPH_W);
   end

endmodule

// File: rtl/overlay_sched.sv
// Font ROM scheduler for two overlay windows on the HDMI stream.
// Window A is a fixed banner, window B a movable glyph string positioned
// through a move_req/move_ack handshake applied at frame start.
// Optional build macro OVL_BLINK_EN: window B blinks with a 64-frame period.
module overlay_sched import overlay_pkg::*; #(
   parameter int H_ACTIVE = 1920,
   parameter int V_ACTIVE = 1080,
   parameter int GLYPH_W  = 8,
   parameter int GLYPH_H  = 16,
   parameter int N_CHARS  = 8,
   parameter int A_X      = 16,
   parameter int A_Y      = 16,
   parameter int A_GLYPH0 = 0,
   parameter int STEP     = 8,
   parameter int ROM_LAT  = 1
) (
   input  logic        HDMI_TX_CLK,
   input  logic        reset_n,
   input  logic        hdmi_de,
   input  logic        hdmi_vs,
   input  logic [12:0] rom_base,
   input  logic        move_req,
   input  logic [1:0]  move_dir,
   input  logic        rom_q,
   output logic        move_ack,
   output logic [12:0] rom_address,
   output logic        overlay_enable,
   output logic        de_aligned,
   output logic [11:0] win_b_x,
   output logic [10:0] win_b_y
);

   localparam logic [11:0] X_MAX  = 12'(H_ACTIVE - N_CHARS * GLYPH_W);
   localparam logic [11:0] Y_MAX  = 12'(V_ACTIVE - GLYPH_H);
   localparam logic [11:0] STEP_V = 12'(STEP);

   logic        de_q;
   logic        vs_q;
   logic        de_fall;
   logic        vs_rise;
   logic [11:0] x_cnt;
   logic [10:0] y_cnt;

   logic              hit_a;
   logic              hit_b_raw;
   logic              hit_b;
   logic [ROM_AW-1:0] addr_a;
   logic [ROM_AW-1:0] addr_b;

   logic               hit_r;
   logic               de_r;
   logic [ROM_LAT-1:0] hit_pipe;
   logic [ROM_LAT-1:0] de_pipe;

   move_state_t state;
   move_dir_t   dir_q;

   // Glyph alignment discards the low address bits of the base.
   logic unused_rom_base_lo;
   assign unused_rom_base_lo = ^rom_base[6:0];

   assign de_fall = de_q & ~hdmi_de;
   assign vs_rise = hdmi_vs & ~vs_q;

   // Pixel position: x counts DE-high cycles, y counts line ends.
   always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
      if (!reset_n) begin
         de_q  <= 1'b0;
         vs_q  <= 1'b0;
         x_cnt <= '0;
         y_cnt <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples the pre-edge values regardless of statement order.
         de_q <= hdmi_de;
         vs_q <= hdmi_vs;
         if (de_fall)
            x_cnt <= '0;
         else if (hdmi_de && x_cnt != 12'(H_ACTIVE - 1))
            x_cnt <= x_cnt + 12'd1;
         if (vs_rise)
            y_cnt <= '0;
         else if (de_fall && y_cnt != 11'(V_ACTIVE - 1))
            y_cnt <= y_cnt + 11'd1;
      end
   end

   overlay_win_hit #(
      .GLYPH_W (GLYPH_W),
      .GLYPH_H (GLYPH_H),
      .N_CHARS (N_CHARS)
   ) u_hit_a (
      .de     (hdmi_de),
      .x      (x_cnt),
      .y      (y_cnt),
      .win_x  (12'(A_X)),
      .win_y  (11'(A_Y)),
      .glyph0 (ROM_AW'(A_GLYPH0)),
      .hit    (hit_a),
      .addr   (addr_a)
   );

   overlay_win_hit #(
      .GLYPH_W (GLYPH_W),
      .GLYPH_H (GLYPH_H),
      .N_CHARS (N_CHARS)
   ) u_hit_b (
      .de     (hdmi_de),
      .x      (x_cnt),
      .y      (y_cnt),
      .win_x  (win_b_x),
      .win_y  (win_b_y),
      .glyph0 ({7'd0, rom_base[12:7]}),
      .hit    (hit_b_raw),
      .addr   (addr_b)
   );

`ifdef OVL_BLINK_EN
   logic [5:0] frame_cnt;

   // Frame counter driving the window B blink phase.
   always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
      if (!reset_n)
         frame_cnt <= '0;
      else if (vs_rise)
         frame_cnt <= frame_cnt + 6'd1;
   end

   assign hit_b = hit_b_raw & ~frame_cnt[5];
`else
   assign hit_b = hit_b_raw;
`endif

   // Address stage: window A wins overlaps; no hit keeps the last address.
   always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
      if (!reset_n) begin
         rom_address <= '0;
         hit_r       <= 1'b0;
         de_r        <= 1'b0;
      end else begin
         hit_r <= hit_a | hit_b;
         de_r  <= hdmi_de;
         // NOTE: the missing else is safe here -- inside a clocked block
         // it just holds the flop; the same shape in combinational logic
         // would infer a latch.
         if (hit_a)
            rom_address <= addr_a;
         else if (hit_b)
            rom_address <= addr_b;
      end
   end

   // Delay hit and DE by the ROM read latency so they line up with rom_q.
   always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
      if (!reset_n) begin
         hit_pipe <= '0;
         de_pipe  <= '0;
      end else begin
         hit_pipe[0] <= hit_r;
         de_pipe[0]  <= de_r;
         for (int i = 1; i < ROM_LAT; i++) begin
            hit_pipe[i] <= hit_pipe[i-1];
            de_pipe[i]  <= de_pipe[i-1];
         end
      end
   end

   assign overlay_enable = hit_pipe[ROM_LAT-1] & rom_q;
   assign de_aligned     = de_pipe[ROM_LAT-1];

   // Move handshake: latch the request, apply it at the next frame start,
   // then hold the acknowledge until the requester lets go.
   always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         dir_q    <= DIR_UP;
         move_ack <= 1'b0;
         win_b_x  <= B_X_RST;
         win_b_y  <= B_Y_RST;
      end else begin
         case (state)
            IDLE: begin
               if (move_req) begin
                  dir_q <= move_dir_t'(move_dir);
                  state <= PEND;
               end
            end
            PEND: begin
               if (vs_rise)
                  state <= APPLY;
            end
            APPLY: begin
               case (dir_q)
                  DIR_UP:    win_b_y <= 11'(step_clamp({1'b0, win_b_y}, 1'b1, STEP_V, Y_MAX));
                  DIR_DOWN:  win_b_y <= 11'(step_clamp({1'b0, win_b_y}, 1'b0, STEP_V, Y_MAX));
                  DIR_LEFT:  win_b_x <= step_clamp(win_b_x, 1'b1, STEP_V, X_MAX);
                  DIR_RIGHT: win_b_x <= step_clamp(win_b_x, 1'b0, STEP_V, X_MAX);
                  default:   ;
               endcase
               move_ack <= 1'b1;
               state    <= ACK;
            end
            ACK: begin
               if (!move_req) begin
                  move_ack <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
